// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared FSM encodings, parity modes and helpers for uart_rx_framed
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PARITY    = 3'd3;
    localparam logic [2:0] c_STOP1     = 3'd4;
    localparam logic [2:0] c_STOP2     = 3'd5;
    localparam logic [2:0] c_WAIT_HIGH = 3'd6;

    localparam logic [1:0] c_PAR_NONE  = 2'b00;
    localparam logic [1:0] c_PAR_EVEN  = 2'b01;
    localparam logic [1:0] c_PAR_ODD   = 2'b10;

    localparam int c_MIN_CPB = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Synchronous first-word fall-through FIFO; head reads 0 when empty
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Push_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Head,
    output logic             o_Full,
    output logic             o_Empty,
    output logic             o_Drop
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_Empty   = (r_count == '0);
    assign o_Full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = i_Pop && !o_Empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign w_do_push = i_Push && (!o_Full || w_do_pop);
    assign o_Drop    = i_Push && o_Full && !w_do_pop;
    assign o_Head    = o_Empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_Push_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_framed
//  Purpose  : UART receiver with parity, 1/2 stop bits, voting and receive FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPB_W      = 14
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_RX_Serial,
    input  logic [CPB_W-1:0]     i_CLKS_PER_BIT,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    input  logic                 i_RX_Ready,
    output logic                 o_RX_Valid,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int                c_BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_BITS - 1);
    localparam int                c_WORD_W   = DATA_BITS + 2;

    logic                 r_sync1, r_sync2;
    logic [2:0]           r_state, w_state_nxt;
    logic [CPB_W-1:0]     r_cnt, r_cpb;
    logic                 r_par_en, r_par_odd, r_two_stop;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0, r_s1, r_perr, r_ferr, r_overrun;

    logic                 w_s, w_start, w_in_frame, w_hit, w_maj;
    logic [CPB_W-1:0]     w_cpb_in, w_target;
    logic                 w_push, w_push_ferr, w_par_calc, w_drop, w_empty, w_full;
    logic [c_WORD_W-1:0]  w_head;

    assign w_s        = r_sync2;
    assign w_cpb_in   = (i_CLKS_PER_BIT < CPB_W'(c_MIN_CPB)) ? CPB_W'(c_MIN_CPB) : i_CLKS_PER_BIT;
    assign w_start    = (r_state == c_IDLE) && !w_s;
    assign w_in_frame = (r_state != c_IDLE) && (r_state != c_WAIT_HIGH);
    // Start bit is judged at its centre; every later bit one full period on
    assign w_target   = (r_state == c_START) ? ((r_cpb - CPB_W'(1)) >> 1) : (r_cpb - CPB_W'(1));
    assign w_hit      = w_in_frame && (r_cnt == w_target);
    assign w_maj      = maj3(r_s0, r_s1, w_s);
    assign w_par_calc = (^r_shift) ^ w_maj;

    assign w_push      = w_hit && (((r_state == c_STOP1) && !r_two_stop) || (r_state == c_STOP2));
    assign w_push_ferr = !w_maj || ((r_state == c_STOP2) && r_ferr);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_Busy      = (r_state != c_IDLE);
        case (r_state)
            c_IDLE:      if (!w_s) w_state_nxt = c_START;
            c_START:     if (w_hit) w_state_nxt = w_maj ? c_IDLE : c_DATA;
            c_DATA:      if (w_hit && (r_bit == c_LAST_BIT)) w_state_nxt = r_par_en ? c_PARITY : c_STOP1;
            c_PARITY:    if (w_hit) w_state_nxt = c_STOP1;
            c_STOP1:     if (w_hit) w_state_nxt = r_two_stop ? c_STOP2 : (w_maj ? c_IDLE : c_WAIT_HIGH);
            c_STOP2:     if (w_hit) w_state_nxt = w_push_ferr ? c_WAIT_HIGH : c_IDLE;
            c_WAIT_HIGH: if (w_s) w_state_nxt = c_IDLE;
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_cnt      <= '0;
            r_cpb      <= CPB_W'(c_MIN_CPB);
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_sync1   <= i_RX_Serial;
            r_sync2   <= r_sync1;
            r_overrun <= w_drop;
            if (w_start) begin
                r_cpb      <= w_cpb_in;
                r_par_en   <= (i_Parity_Mode == c_PAR_EVEN) || (i_Parity_Mode == c_PAR_ODD);
                r_par_odd  <= (i_Parity_Mode == c_PAR_ODD);
                r_two_stop <= i_Two_Stop;
                r_bit      <= '0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (!w_in_frame || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CPB_W'(1);
            end
            if (w_in_frame && (r_cnt == w_target - CPB_W'(2))) r_s0 <= w_s;
            if (w_in_frame && (r_cnt == w_target - CPB_W'(1))) r_s1 <= w_s;
            if (w_hit) begin
                case (r_state)
                    c_DATA: begin
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + c_BIT_W'(1);
                    end
                    c_PARITY: r_perr <= r_par_odd ? !w_par_calc : w_par_calc;
                    c_STOP1:  r_ferr <= !w_maj;
                    default: ;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Push      (w_push),
        .i_Push_Data ({w_push_ferr, r_perr, r_shift}),
        .i_Pop       (o_RX_Valid && i_RX_Ready),
        .o_Head      (w_head),
        .o_Full      (w_full),
        .o_Empty     (w_empty),
        .o_Drop      (w_drop)
    );

    assign o_RX_Valid   = !w_empty;
    assign o_RX_Data    = w_head[DATA_BITS-1:0];
    assign o_Parity_Err = w_head[DATA_BITS];
    assign o_Frame_Err  = w_head[DATA_BITS+1];
    assign o_Overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_framed
//  Purpose  : Scoreboard bench for uart_rx_framed (8-bit and 9-bit instances)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx8 = 1'b1;
    logic        rx9 = 1'b1;
    logic [13:0] cpb;
    logic [1:0]  pmode;
    logic        two_stop;
    logic        ready;

    logic       v8, pe8, fe8, ov8, busy8;
    logic [7:0] d8;
    logic       v9, pe9, fe9, ov9, busy9;
    logic [8:0] d9;

    int total = 0;
    int bad   = 0;
    int ov8_cnt = 0;
    int ov9_cnt = 0;
    logic [10:0] q8[$];
    logic [10:0] q9[$];
    logic [10:0] exp8, exp9;

    always #5 clk = ~clk;

    uart_rx_framed #(.DATA_BITS(8), .FIFO_DEPTH(4), .CPB_W(14)) dut8 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx8), .i_CLKS_PER_BIT(cpb),
        .i_Parity_Mode(pmode), .i_Two_Stop(two_stop), .i_RX_Ready(ready),
        .o_RX_Valid(v8), .o_RX_Data(d8), .o_Parity_Err(pe8), .o_Frame_Err(fe8),
        .o_Overrun(ov8), .o_Busy(busy8)
    );

    uart_rx_framed #(.DATA_BITS(9), .FIFO_DEPTH(4), .CPB_W(14)) dut9 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx9), .i_CLKS_PER_BIT(cpb),
        .i_Parity_Mode(pmode), .i_Two_Stop(two_stop), .i_RX_Ready(ready),
        .o_RX_Valid(v9), .o_RX_Data(d9), .o_Parity_Err(pe9), .o_Frame_Err(fe9),
        .o_Overrun(ov9), .o_Busy(busy9)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic b);
        if (sel) rx9 = b;
        else     rx8 = b;
    endtask

    // Frame word stored as {frame_err, parity_err, data[8:0]}
    task automatic send(input bit sel, input int nbits, input logic [8:0] data,
                        input bit has_par, input logic pbit, input int nstop,
                        input logic [2:0] stops, input int lcpb,
                        input int glitch_pos, input int rst_pos);
        logic [15:0] bits;
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
        n = 1 + nbits;
        if (has_par) begin
            bits[n] = pbit;
            n = n + 1;
        end
        for (int j = 0; j < nstop; j++) bits[n+j] = stops[j];
        n = n + nstop;
        for (int k = 0; k < n; k++) begin
            set_line(sel, bits[k]);
            for (int c = 0; c < lcpb; c++) begin
                if (k == glitch_pos && c == lcpb/2)     set_line(sel, ~bits[k]);
                if (k == glitch_pos && c == lcpb/2 + 1) set_line(sel, bits[k]);
                if (k == rst_pos && c == lcpb/2)        rst_n = 1'b0;
                if (k == rst_pos && c == lcpb/2 + 1)    rst_n = 1'b1;
                tick(1);
            end
        end
        set_line(sel, 1'b1);
        tick(2 * lcpb);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8) ov8_cnt++;
            if (ov9) ov9_cnt++;
            if (v8 && ready) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut8 unexpected word: got %0h expected none", {fe8, pe8, 1'b0, d8});
                end else begin
                    exp8 = q8.pop_front();
                    check("dut8 word", 32'({fe8, pe8, 1'b0, d8}), 32'(exp8));
                end
            end
            if (v9 && ready) begin
                if (q9.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut9 unexpected word: got %0h expected none", {fe9, pe9, d9});
                end else begin
                    exp9 = q9.pop_front();
                    check("dut9 word", 32'({fe9, pe9, d9}), 32'(exp9));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cpb = 14'd10; pmode = 2'b00; two_stop = 1'b0; ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("reset outputs dut8", 32'({v8, d8, pe8, fe8, ov8, busy8}), 32'd0);
        check("reset outputs dut9", 32'({v9, d9, pe9, fe9, ov9, busy9}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5);

        // 8N1 at cpb=10, consumer stalled
        q8.push_back({2'b00, 9'h0A5});
        send(0, 8, 9'h0A5, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        @(negedge clk);
        check("valid while stalled", 32'({v8, d8}), 32'h1A5);
        tick(30);
        @(negedge clk);
        check("valid still held", 32'(v8), 32'd1);
        tick(1);
        ready = 1'b1;
        tick(3);
        @(negedge clk);
        check("empty after pop", 32'(v8), 32'd0);
        tick(1);

        // 0x03 has even data parity; parity bit 1 is wrong for even, right for odd
        pmode = 2'b01;
        q8.push_back({2'b01, 9'h003});
        send(0, 8, 9'h003, 1, 1'b1, 1, 3'b001, 10, -1, -1);
        pmode = 2'b10;
        q8.push_back({2'b00, 9'h003});
        send(0, 8, 9'h003, 1, 1'b1, 1, 3'b001, 10, -1, -1);
        pmode = 2'b00;

        // stop bit held low for three bit times, then a clean frame
        cpb = 14'd16;
        q8.push_back({2'b10, 9'h05A});
        send(0, 8, 9'h05A, 0, 1'b0, 3, 3'b000, 16, -1, -1);
        q8.push_back({2'b00, 9'h03C});
        send(0, 8, 9'h03C, 0, 1'b0, 1, 3'b001, 16, -1, -1);

        // 2-cycle low pulse is rejected as a glitch
        rx8 = 1'b0;
        tick(2);
        rx8 = 1'b1;
        tick(40);
        @(negedge clk);
        check("short pulse busy", 32'(busy8), 32'd0);
        check("short pulse valid", 32'(v8), 32'd0);
        tick(1);

        // 1-cycle glitch at data bit 3 centre is outvoted
        q8.push_back({2'b00, 9'h000});
        send(0, 8, 9'h000, 0, 1'b0, 1, 3'b001, 16, 4, -1);

        // fill 4-deep FIFO, fifth word overruns
        cpb = 14'd10;
        ready = 1'b0;
        q8.push_back({2'b00, 9'h011});
        q8.push_back({2'b00, 9'h022});
        q8.push_back({2'b00, 9'h033});
        q8.push_back({2'b00, 9'h044});
        send(0, 8, 9'h011, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        send(0, 8, 9'h022, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        send(0, 8, 9'h033, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        send(0, 8, 9'h044, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        send(0, 8, 9'h055, 0, 1'b0, 1, 3'b001, 10, -1, -1);
        @(negedge clk);
        check("full head", 32'({v8, d8}), 32'h111);
        check("overrun pulses", 32'(ov8_cnt), 32'd1);
        tick(1);

        // Stop decision edge = 2 sync + 1 detect + (h+1) + 9*cpb = 98 for cpb=10
        q8.push_back({2'b00, 9'h066});
        fork
            send(0, 8, 9'h066, 0, 1'b0, 1, 3'b001, 10, -1, -1);
            begin
                tick(97);
                ready = 1'b1;
                @(negedge clk);
                check("busy before stop decision", 32'({busy8, v8}), 32'h3);
                tick(1);
                ready = 1'b0;
                @(negedge clk);
                check("busy after stop decision", 32'({busy8, v8}), 32'h1);
            end
        join
        tick(3);
        @(negedge clk);
        check("no overrun on push+pop", 32'(ov8_cnt), 32'd1);
        tick(1);
        ready = 1'b1;
        tick(20);
        @(negedge clk);
        check("dut8 queue drained", 32'(q8.size()), 32'd0);
        tick(1);

        // reset pulse during data bit 4 drops the frame
        send(0, 8, 9'h0FF, 0, 1'b0, 1, 3'b001, 10, -1, 5);
        @(negedge clk);
        check("outputs after mid-frame reset", 32'({v8, d8, pe8, fe8, ov8, busy8}), 32'd0);
        tick(1);

        // rate change mid-frame is ignored until the next frame
        q8.push_back({2'b00, 9'h096});
        fork
            send(0, 8, 9'h096, 0, 1'b0, 1, 3'b001, 10, -1, -1);
            begin
                tick(25);
                cpb = 14'd20;
            end
        join
        cpb = 14'd10;
        tick(5);

        // 9 data bits, two stop bits
        cpb = 14'd8;
        two_stop = 1'b1;
        q9.push_back({2'b00, 9'h1A5});
        send(1, 9, 9'h1A5, 0, 1'b0, 2, 3'b011, 8, -1, -1);
        q9.push_back({2'b10, 9'h0F3});
        send(1, 9, 9'h0F3, 0, 1'b0, 2, 3'b001, 8, -1, -1);
        cpb = 14'd4;
        q9.push_back({2'b00, 9'h155});
        send(1, 9, 9'h155, 0, 1'b0, 2, 3'b011, 8, -1, -1);
        tick(5);

        @(negedge clk);
        check("dut8 queue empty", 32'(q8.size()), 32'd0);
        check("dut9 queue empty", 32'(q9.size()), 32'd0);
        check("dut9 no overrun", 32'(ov9_cnt), 32'd0);
        check("dut9 idle", 32'({busy9, v9}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
